// File: rtl/wb_wbuf32.sv
// Posted-write buffer: acks CPU writes into a small FIFO and drains them in order to the SRAM controller.
// Optional WBUF_READ_BYPASS_EN lets reads overtake buffered writes to other words.
module wb_wbuf32 #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        wbuf_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t state, state_nxt;

    logic [29:0] fifo_adr [DEPTH];
    logic [3:0]  fifo_sel [DEPTH];
    logic [31:0] fifo_dat [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    logic req, rd_req, full, push, pop, read_ok;
    logic start_wr, start_rd;
    logic unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign req    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign rd_req = req & ~wbs_we_i;
    // count can only reach DEPTH, so its top bit alone flags full
    assign full   = count[DEPTH_LOG2];
    assign push   = req & wbs_we_i & ~full;
    assign pop    = (state == WR) & wbm_ack_i;

`ifdef WBUF_READ_BYPASS_EN
    logic                  hit;
    logic [DEPTH_LOG2-1:0] off;

    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = i[DEPTH_LOG2-1:0] - rd_ptr;
            if (({1'b0, off} < count) && (fifo_adr[i] == wbs_adr_i[31:2]))
                hit = 1'b1;
        end
    end

    assign read_ok = ~hit;
`else
    assign read_ok = (count == '0);
`endif

    always_comb begin
        state_nxt = state;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req && read_ok) begin
                    start_rd  = 1'b1;
                    state_nxt = RD;
                end else if (count != '0) begin
                    start_wr  = 1'b1;
                    state_nxt = WR;
                end
            end
            WR:      if (wbm_ack_i) state_nxt = IDLE;
            RD:      if (wbm_ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_adr[wr_ptr] <= wbs_adr_i[31:2];
            fifo_sel[wr_ptr] <= wbs_sel_i;
            fifo_dat[wr_ptr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_sel_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};

            wbs_ack_o <= push | ((state == RD) & wbm_ack_i);
            if ((state == RD) && wbm_ack_i)
                wbs_dat_o <= wbm_dat_i;

            if (start_wr) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= 1'b1;
                wbm_adr_o <= {fifo_adr[rd_ptr], 2'b00};
                wbm_sel_o <= fifo_sel[rd_ptr];
                wbm_dat_o <= fifo_dat[rd_ptr];
            end else if (start_rd) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= 1'b0;
                wbm_adr_o <= {wbs_adr_i[31:2], 2'b00};
                wbm_sel_o <= wbs_sel_i;
            end else if ((state != IDLE) && wbm_ack_i) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
            end
        end
    end

    assign wbuf_empty = (count == '0) && (state != WR);

endmodule

// File: doc/wb_wbuf32.md
# wb_wbuf32

Posted-write buffer between the CPU-side 32-bit Wishbone master and the 32-bit SRAM controller. It acknowledges CPU writes as soon as they enter a small FIFO and drains them to the controller in order, so byte writes and their read-modify-write cycles no longer stall the core. Reads are forwarded downstream once the ordering rule below allows; read data is returned with a single-cycle ack.

## Interface
Parameters:
- DEPTH_LOG2, 2, log2 of FIFO entries (4 entries); legal 1..4
Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wbs_stb_i / wbs_cyc_i / wbs_we_i  in  1 each  upstream request
- wbs_adr_i  in  32  byte address; bits [1:0] ignored
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1
- wbs_ack_o  out  1  one-cycle registered acknowledge
- wbm_stb_o / wbm_cyc_o / wbm_we_o  out  1 each  downstream request
- wbm_adr_o  out  32  word address in [31:2]; [1:0] always 0
- wbm_sel_o  out  4  byte selects
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  downstream read data
- wbm_ack_i  in  1  downstream acknowledge
- wbuf_empty  out  1  FIFO empty and no downstream write in flight

## Operation
- Request seen when wbs_stb_i & wbs_cyc_i & ~wbs_ack_o.
- FIFO entry = {adr[31:2], sel, dat}; count register DEPTH_LOG2+1 bits; wrapping read/write pointers.
- Write: accepted when count < 2^DEPTH_LOG2 and no read pending → push, wbs_ack_o=1 next cycle. Full → no ack; request held until accepted. Full with a pop in the same cycle: push NOT accepted that cycle; accepted the next.
- Drain FSM states: IDLE, WR, RD.
  - IDLE, no eligible read, FIFO non-empty → load head onto wbm_*, wbm_cyc_o=wbm_stb_o=wbm_we_o=1, go WR.
  - WR: hold outputs until wbm_ack_i; on ack pop head, drop cyc/stb/we, go IDLE (at least one idle cycle between downstream transactions).
  - IDLE with eligible read → drive wbm_adr_o={adr[31:2],2'b00}, wbm_sel_o=wbs_sel_i, we=0, cyc=stb=1, go RD.
  - RD: on wbm_ack_i capture wbm_dat_i into wbs_dat_o, pulse wbs_ack_o, drop cyc/stb, go IDLE.
- Read eligibility (default): FIFO empty and FSM IDLE. Reads have priority over new drains once eligible.
- wbs_dat_o holds its last captured value; it is 0 after reset.
- Reset at any point: FIFO emptied (buffered writes discarded), FSM to IDLE, in-flight downstream cycle abandoned (cyc/stb low next cycle).
- Reset values: wbs_ack_o=0, wbs_dat_o=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=0, wbm_sel_o=0, wbm_dat_o=0, wbuf_empty=1.

## Timing
- Write ack: request first seen at edge N → wbs_ack_o high during cycle N+1 only.
- Entry pushed at edge N into an empty, idle buffer → wbm_stb_o high from edge N+1.
- Downstream write occupancy: (controller latency) + 1 idle cycle per entry.
- Read latency, empty buffer: request at edge N → wbm_stb_o at N+1 → ack from controller at edge M → wbs_ack_o during cycle M+1.
- wbuf_empty falls in the cycle after a push, rises in the cycle after the last pop.

## Configuration
- WBUF_READ_BYPASS_EN defined: a read is eligible when FSM is IDLE and no valid FIFO entry matches adr[31:2] (compare across all valid entries). Reads then overtake non-conflicting buffered writes. On a match, draining continues until no matching entry remains.
- Undefined: reads wait for a full drain (strict ordering); no compare logic is built.

## Test plan
- Single write adr=0x100, sel=0xF, dat=0xDEADBEEF → wbs_ack_o one cycle after request; downstream write with wbm_adr_o=0x100, wbm_sel_o=0xF, wbm_dat_o=0xDEADBEEF.
- 5 back-to-back writes, DEPTH_LOG2=2, downstream ack delayed 3 cycles → writes 1–4 acked immediately, 5th stalls until first pop plus one cycle; downstream order preserved.
- Write 0x200=0x11223344, then read 0x200 (default build) → read issued only after write acked downstream; wbs_dat_o=0x11223344.
- With WBUF_READ_BYPASS_EN: buffer writes to 0x300 and 0x304, read 0x400 → read issued before the drains complete. Read 0x304 → waits until the 0x304 entry pops.
- Byte write sel=0x2 dat=0x0000AB00 → wbm_sel_o=0x2 passed through unchanged.
- Reset asserted during a downstream WR with 3 entries buffered → next cycle wbm_cyc_o=0, wbuf_empty=1, wbs_ack_o=0; no further downstream cycles.
